fifo_uart_tx: RTL and testbench

Downstream consumer of the 8-entry byte FIFO. Pops one byte at a time when the FIFO is non-empty and serializes it onto a UART TX line: start bit, 8 data bits LSB first, stop bit. Works with the FIFO's one-cycle registered read latency. Sits between the FIFO and the chip-level serial pin.

---
 rtl/fifo_uart_pkg.sv | 17 +
 rtl/uart_bit_timer.sv | 32 +++
 rtl/fifo_uart_tx.sv | 130 +++++++++++++
 tb/tb_fifo_uart_tx.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_uart_pkg.sv
// rtl/fifo_uart_pkg.sv - shared state encoding and defaults for the FIFO-fed UART transmitter
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD     = 3'd1,
    CAP    = 3'd2,
    START  = 3'd3,
    DATA   = 3'd4,
    PARITY = 3'd5,
    STOP   = 3'd6
  } tx_state_t;

  localparam int DATA_W_DEF       = 8;
  localparam int CLKS_PER_BIT_DEF = 868;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - baud counter producing a strobe on the last clock of each bit period
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_tick,
  output logic bit_pre_tick
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] PRE_LAST = CNT_W'(CLKS_PER_BIT - 2);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // pre-tick lets the owner register a pulse that lands on the final cycle
  assign bit_tick     = (cnt == LAST);
  assign bit_pre_tick = (cnt == PRE_LAST);

endmodule

// File: rtl/fifo_uart_tx.sv
// rtl/fifo_uart_tx.sv - pops bytes from the byte FIFO and serializes them as 8N1 UART frames
// Optional even-parity bit when FIFO_UART_TX_PARITY_EN is defined.
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int DATA_W       = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fifo_empty,
  input  logic [DATA_W-1:0] fifo_data,
  output logic              fifo_rd,
  output logic              tx,
  output logic              busy,
  output logic              frame_done
);

  localparam int BIT_W = $clog2(DATA_W);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_W - 1);

  tx_state_t         state;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              bit_tick;
  logic              bit_pre_tick;
  logic              timer_clr;
`ifdef FIFO_UART_TX_PARITY_EN
  logic              parity_bit;
`endif

  assign timer_clr = (state == CAP);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk          (clk),
    .rst          (rst),
    .clr          (timer_clr),
    .bit_tick     (bit_tick),
    .bit_pre_tick (bit_pre_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      fifo_rd    <= 1'b0;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
`ifdef FIFO_UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      fifo_rd    <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (enable && !fifo_empty) begin
            state   <= RD;
            fifo_rd <= 1'b1;
            busy    <= 1'b1;
          end
        end
        RD: begin
          state <= CAP;
        end
        // fifo_data is valid here, one cycle after the read strobe
        CAP: begin
          shift_reg <= fifo_data;
`ifdef FIFO_UART_TX_PARITY_EN
          parity_bit <= ^fifo_data;
`endif
          bit_cnt   <= '0;
          tx        <= 1'b0;
          state     <= START;
        end
        START: begin
          if (bit_tick) begin
            tx        <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            state     <= DATA;
          end
        end
        DATA: begin
          if (bit_tick) begin
            if (bit_cnt == LAST_BIT) begin
`ifdef FIFO_UART_TX_PARITY_EN
              tx    <= parity_bit;
              state <= PARITY;
`else
              tx    <= 1'b1;
              state <= STOP;
`endif
            end else begin
              tx        <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
              bit_cnt   <= bit_cnt + BIT_W'(1);
            end
          end
        end
`ifdef FIFO_UART_TX_PARITY_EN
        PARITY: begin
          if (bit_tick) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end
`endif
        STOP: begin
          if (bit_pre_tick) frame_done <= 1'b1;
          if (bit_tick) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb/tb_fifo_uart_tx.sv - directed bench for fifo_uart_tx with a behavioural byte FIFO
module tb_fifo_uart_tx;

  localparam int CPB = 4;
`ifdef FIFO_UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int NS = NB * CPB;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic       fifo_empty;
  logic [7:0] fifo_data;
  logic       fifo_rd;
  logic       tx;
  logic       busy;
  logic       frame_done;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rd_cnt   = 0;
  int fd_cnt   = 0;

  logic [7:0] mem [16];
  int wp = 0;
  int rp = 0;

  always #5 clk = ~clk;

  fifo_uart_tx #(
    .CLKS_PER_BIT(CPB),
    .DATA_W(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_rd    (fifo_rd),
    .tx         (tx),
    .busy       (busy),
    .frame_done (frame_done)
  );

  assign fifo_empty = (wp == rp);

  // registered-read FIFO: data appears the cycle after the strobe
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd) begin
      fifo_data <= mem[rp % 16];
      rp        <= rp + 1;
      rd_cnt    <= rd_cnt + 1;
    end
    if (frame_done) fd_cnt <= fd_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wp % 16] = b;
    wp = wp + 1;
  endtask

  task automatic wait_start(input string tag, output int start_cyc);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (tx === 1'b0) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    start_cyc = cyc;
    check({tag, "_start_seen"}, {31'd0, found}, 32'd1);
  endtask

  // call on the negedge of the first start-bit cycle
  task automatic sample_frame(input string tag, input logic [7:0] exp);
    logic [NS-1:0] s;
    logic [NS-1:0] fd;
    logic [NB-1:0] exp_bits;
    logic [7:0]    got;
    int            bit_err;
    int            fd_ones;
    for (int i = 0; i < NS; i++) begin
      s[i]  = tx;
      fd[i] = frame_done;
      @(negedge clk);
    end
    exp_bits          = '1;
    exp_bits[0]       = 1'b0;
    exp_bits[8:1]     = exp;
`ifdef FIFO_UART_TX_PARITY_EN
    exp_bits[9]       = ^exp;
`endif
    bit_err = 0;
    fd_ones = 0;
    for (int i = 0; i < NS; i++) begin
      if (s[i] !== exp_bits[i / CPB]) bit_err++;
      if (fd[i] === 1'b1) fd_ones++;
    end
    for (int k = 0; k < 8; k++) got[k] = s[(k + 1) * CPB + CPB / 2];
    check({tag, "_data"}, {24'd0, got}, {24'd0, exp});
    check({tag, "_bit_errors"}, bit_err, 0);
    check({tag, "_done_last"}, {31'd0, fd[NS-1]}, 32'd1);
    check({tag, "_done_count"}, fd_ones, 1);
`ifdef FIFO_UART_TX_PARITY_EN
    check({tag, "_parity"}, {31'd0, s[9 * CPB + 1]}, {31'd0, ^exp});
`endif
  endtask

  initial begin
    int sc;
    int prev_end;
    int viol;
    int rd0;
    int fd0;
    int lat;
    logic seen;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_fifo_rd", {31'd0, fifo_rd}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_frame_done", {31'd0, frame_done}, 32'd0);
    rst = 1'b0;

    // empty FIFO with enable: no activity
    enable = 1'b1;
    viol = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || fifo_rd !== 1'b0 || busy !== 1'b0) viol++;
    end
    check("idle_empty_violations", viol, 0);
    check("idle_empty_rd_count", rd_cnt, 0);

    // single byte 0xA5
    push(8'hA5);
    wait_start("a5", sc);
    check("a5_busy", {31'd0, busy}, 32'd1);
    sample_frame("a5", 8'hA5);
    check("a5_rd_count", rd_cnt, 1);

    // three bytes queued before enable
    enable = 1'b0;
    @(negedge clk);
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    repeat (5) @(negedge clk);
    check("queued_no_rd_while_disabled", rd_cnt, 1);
    enable = 1'b1;
    wait_start("b00", sc);
    sample_frame("b00", 8'h00);
    prev_end = sc + NS - 1;
    wait_start("bff", sc);
    check("gap_00_ff", sc - prev_end - 1, 3);
    sample_frame("bff", 8'hFF);
    prev_end = sc + NS - 1;
    wait_start("b3c", sc);
    check("gap_ff_3c", sc - prev_end - 1, 3);
    sample_frame("b3c", 8'h3C);
    check("three_rd_count", rd_cnt, 4);
    check("three_fifo_empty", {31'd0, fifo_empty}, 32'd1);

    // reset during data bit 3 of 0x55
    push(8'h55);
    push(8'h96);
    wait_start("r55", sc);
    fd0 = fd_cnt;
    repeat (17) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_tx", {31'd0, tx}, 32'd1);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_state", {29'd0, dut.state}, 32'd0);
    check("midrst_no_done", fd_cnt, fd0);
    wait_start("r96", sc);
    sample_frame("r96", 8'h96);

    // enable dropped during start bit of 0x81
    push(8'h81);
    push(8'h42);
    wait_start("e81", sc);
    enable = 1'b0;
    sample_frame("e81", 8'h81);
    rd0 = rd_cnt;
    repeat (50) @(negedge clk);
    check("disabled_no_rd", rd_cnt, rd0);
    check("disabled_not_empty", {31'd0, fifo_empty}, 32'd0);
    enable = 1'b1;
    seen = 1'b0;
    lat = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      lat++;
      if (fifo_rd === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check("resume_rd_within_3", {31'd0, seen}, 32'd1);
    wait_start("e42", sc);
    sample_frame("e42", 8'h42);

`ifdef FIFO_UART_TX_PARITY_EN
    push(8'h07);
    wait_start("p07", sc);
    sample_frame("p07", 8'h07);
    push(8'h03);
    wait_start("p03", sc);
    sample_frame("p03", 8'h03);
`endif

    repeat (5) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
